// File: rtl/uart_rx_os_pkg.sv
// Package for the oversampling UART receiver: frame constants, state codes, 3-input majority.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_rx_os_pkg;
  `include "uart_defs.vh"

  // Bit index covers data bits plus stop bits of one frame.
  localparam int IDX_W = $clog2(UART_DBITS + UART_STOP);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_defs.vh
// Shared UART frame definitions: receiver state encodings and 8n1 frame constants.
// Latency: n/a (constants only).
// Backpressure: n/a.
`ifndef UART_DEFS_VH
`define UART_DEFS_VH

localparam logic [2:0] ST_IDLE  = 3'd0;
localparam logic [2:0] ST_START = 3'd1;
localparam logic [2:0] ST_DATA  = 3'd2;
localparam logic [2:0] ST_STOP  = 3'd3;
localparam logic [2:0] ST_BRK   = 3'd4;

localparam int UART_DBITS = 8;
localparam int UART_STOP  = 1;

`endif

// File: rtl/uart_rx_sampler.sv
// Line conditioner: 2-flop synchronizer on the async UART line, optional 3-tap majority filter.
// Latency: 2 clk from in to s (3 clk with UART_RX_MAJORITY_EN defined).
// Backpressure: none; free-running sampler.
// Ports: clk, rst (sync, active-high), in (async line, idle high) -> s (conditioned sample).
// Macro UART_RX_MAJORITY_EN: adds two history flops and votes over the last three in_s values.
module uart_rx_sampler
  import uart_rx_os_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic s
);

  logic sync1;
  logic in_s;

  // Sync flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      in_s  <= 1'b1;
    end else begin
      sync1 <= in;
      in_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic hist1;
  logic hist2;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist1 <= 1'b1;
      hist2 <= 1'b1;
    end else begin
      hist1 <= in_s;
      hist2 <= hist1;
    end
  end

  // A single-cycle pulse can only ever be one of three votes.
  assign s = maj3(in_s, hist1, hist2);
`else
  assign s = in_s;
`endif

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8n1 UART receiver: LSB-first byte recovery, false-start rejection, framing-error detect.
// Latency: OS/2+9*OS+1 clk from start detect to data_rdy (+2 sync, +1 more with majority filter).
// Backpressure: none; data_rdy/ferr are one-cycle strobes, the consumer must take them.
// Ports: clk (OS x baud), rst (sync, active-high), in (async line), data (last good byte),
//        data_rdy (data updated pulse), ferr (stop bit low pulse), busy (state != IDLE).
// Macro UART_RX_MAJORITY_EN selects the majority-filtered sampler.
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int OS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic [7:0] data,
  output logic       data_rdy,
  output logic       ferr,
  output logic       busy
);

  localparam int            CW      = $clog2(OS);
  localparam logic [CW-1:0] HALF_M1 = CW'(OS / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DBITS - 1);

  logic                  s;
  logic [2:0]            state;
  logic [CW-1:0]         cnt;
  logic [IDX_W-1:0]      idx;
  logic [UART_DBITS-1:0] sr;

  uart_rx_sampler u_sampler (
    .clk (clk),
    .rst (rst),
    .in  (in),
    .s   (s)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      idx      <= '0;
      sr       <= '0;
      data     <= 8'h00;
      data_rdy <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      data_rdy <= 1'b0;
      ferr     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!s) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        // Re-check the line at mid start bit; a high level means a glitch.
        ST_START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (!s) begin
              state <= ST_DATA;
              idx   <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // From mid start, every OS cycles lands at mid bit; shift in from the top (LSB first).
        ST_DATA: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            sr  <= {s, sr[UART_DBITS-1:1]};
            idx <= idx + 1'b1;
            if (idx == LAST_IDX) begin
              state <= ST_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Leave at mid stop bit so the next start edge is caught even with a fast transmitter.
        ST_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (s) begin
              data     <= sr;
              data_rdy <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              ferr  <= 1'b1;
              state <= ST_BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Hold here through a break so it reports only one ferr.
        ST_BRK: begin
          if (s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os (OS=16): directed frames with expected bytes/errors queued at send time,
// a negedge monitor pops and compares each data_rdy/ferr strobe including its exact cycle.
module tb_uart_rx_os;

  logic       clk;
  logic       rst;
  logic       line;
  logic [7:0] data;
  logic       data_rdy;
  logic       ferr;
  logic       busy;

  // Start edge driven after posedge c0 -> strobe visible in cycle c0 + 2 (sync) + 153.
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = 156;
`else
  localparam int LAT = 155;
`endif

  typedef struct {
    bit         is_ferr;
    logic [7:0] dat;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  uart_rx_os #(.OS(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (line),
    .data     (data),
    .data_rdy (data_rdy),
    .ferr     (ferr),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit f, input logic [7:0] d);
    exp_q.push_back('{is_ferr: f, dat: d, cyc: cyc + LAT});
  endtask

  // Drives one frame; p2 is the bit period in half clocks so periods like 15.5 are possible.
  // cut>0 abandons the frame (line high) after that many cycles; glitch_bit flips one mid-bit cycle.
  task automatic send_frame(input logic [7:0] b, input int p2, input bit stop_ok,
                            input int cut, input int glitch_bit);
    logic [9:0] frame;
    int n;
    int len;
    frame = {stop_ok, b, 1'b0};
    n = 0;
    for (int k = 0; k < 10; k++) begin
      len = ((k + 1) * p2) / 2 - (k * p2) / 2;
      for (int j = 0; j < len; j++) begin
        if (cut > 0 && n == cut) begin
          line = 1'b1;
          return;
        end
        line = frame[k] ^ ((k == glitch_bit) && (j == len / 2));
        @(posedge clk);
        #1;
        n++;
      end
    end
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && (data_rdy || ferr)) begin
      chk("rdy_ferr_exclusive", int'(data_rdy & ferr), 0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event data_rdy=%0b ferr=%0b data=%0h required=no_event cycle=%0d",
                 data_rdy, ferr, data, cyc);
      end else begin
        e_mon = exp_q.pop_front();
        chk("event_is_ferr", int'(ferr), int'(e_mon.is_ferr));
        chk("event_data", int'(data), int'(e_mon.dat));
        chk("event_cycle", cyc, e_mon.cyc);
        if (data_rdy) chk("busy_low_at_rdy", int'(busy), 0);
      end
    end
  end

  initial begin
    int gb;
    rst  = 1'b1;
    line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_data", int'(data), 8'h00);
    chk("reset_data_rdy", int'(data_rdy), 0);
    chk("reset_ferr", int'(ferr), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(10);

    // Clean 0xA5 at 16 clk/bit, busy checked mid-frame.
    push(1'b0, 8'hA5);
    fork
      send_frame(8'hA5, 32, 1'b1, 0, -1);
      begin
        repeat (100) @(posedge clk);
        #1;
        chk("busy_mid_frame", int'(busy), 1);
      end
    join
    idle(20);

    // 4-cycle low glitch on idle line: START aborts, nothing reported.
    line = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(30);
    chk("busy_after_false_start", int'(busy), 0);

    // 0x3C with low stop bit, line held low: one ferr, data keeps 0xA5.
    push(1'b1, 8'hA5);
    send_frame(8'h3C, 32, 1'b0, 0, -1);
    line = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("busy_in_break", int'(busy), 1);
    idle(20);
    chk("busy_after_break", int'(busy), 0);
    push(1'b0, 8'h11);
    send_frame(8'h11, 32, 1'b1, 0, -1);
    idle(20);

    // Back-to-back frames with ~3% slow and fast transmitter.
    push(1'b0, 8'h00);
    send_frame(8'h00, 31, 1'b1, 0, -1);
    push(1'b0, 8'hFF);
    send_frame(8'hFF, 33, 1'b1, 0, -1);
    idle(20);

    // Reset during data bit 3 of 0x5A (transmitter abandons too).
    send_frame(8'h5A, 32, 1'b1, 70, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_data", int'(data), 8'h00);
    chk("rst_mid_data_rdy", int'(data_rdy), 0);
    chk("rst_mid_ferr", int'(ferr), 0);
    chk("rst_mid_busy", int'(busy), 0);
    rst = 1'b0;
    idle(20);
    push(1'b0, 8'h5A);
    send_frame(8'h5A, 32, 1'b1, 0, -1);
    idle(20);

    // Loopback-style stream 0x00..0xFF, back-to-back; glitches only when filtered.
    for (int b = 0; b < 256; b++) begin
`ifdef UART_RX_MAJORITY_EN
      gb = b % 10;
`else
      gb = -1;
`endif
      push(1'b0, 8'(b));
      send_frame(8'(b), 32, 1'b1, 0, gb);
    end
    idle(200);
    chk("all_events_seen", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
